sevenseg_capture: RTL
=====================

# sevenseg_capture

- Receive-side monitor for the four-digit, active-low multiplexed seven-segment bus driven by the shot-clock display path (`an`, `seg`, `dp`).
- Samples the bus in the `CLK100MHZ` domain and waits for each digit's dwell to settle.
- Decodes the segment pattern back to a hex value and holds the last good value for each digit.
- Used in-system as a self-check of the display path and as the bench's display scoreboard.

## Interface
- `SETTLE_CYCLES`, 16: consecutive identical synced samples needed to accept a digit (≥2).
- `STALE_CYCLES`, 2**22: cycles without a re-accept before a digit's `seen` bit clears.
- `DIGIT_MASK`, 4'b1111: digits that must be accepted before `frame_done` pulses.
- `CLK100MHZ`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `an`  in  4  anode enables, active-low. Bit *i* selects digit *i*.
- `seg`  in  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- `dp`  in  1  decimal point, active-low.
- `d3`,`d2`,`d1`,`d0`  out  4 each  last accepted hex value per digit.
- `blank`  out  4  digit last accepted as all segments off.
- `dp_out`  out  4  accepted decimal point per digit, active-high.
- `seen`  out  4  digit accepted within the last `STALE_CYCLES`.
- `upd`  out  1  one-cycle pulse on each accept.
- `upd_idx`  out  2  index of the accepted digit, valid with `upd`.
- `frame_done`  out  1  one-cycle pulse when every `DIGIT_MASK` digit has been accepted since the previous pulse.
- `illegal`  out  1  one-cycle pulse when a settled pattern does not decode.
- `conflict`  out  1  one-cycle pulse on entry to CONFLICT.

## Operation
- **Synchronizer:** two flops on {`an`,`seg`,`dp`}. Reset value is all-ones, which reads as idle.
- **Anode classification** (synced `an`):
  - no bit low: idle.
  - exactly one bit low: active, with index *i*.
  - more than one bit low: conflict.
- **Stability counter:** clears whenever the synced 12-bit sample differs from the previous cycle's sample. Otherwise it increments and saturates at `SETTLE_CYCLES-1`.
- **Dwell FSM states:** IDLE, SETTLE, HELD, CONFLICT.
  - IDLE → SETTLE: one anode is active.
  - IDLE → CONFLICT: multiple anodes are active.
  - SETTLE → HELD: the counter reaches `SETTLE_CYCLES-1`. This performs one decode attempt.
  - SETTLE or HELD → SETTLE: any sample change while one anode is active.
  - SETTLE or HELD → IDLE: no anode is active.
  - HELD → CONFLICT, SETTLE → CONFLICT: multiple anodes become active.
  - CONFLICT → IDLE or SETTLE: decided on the anode classification of the same cycle.
  - HELD never re-accepts. One accept per stable dwell.
- **Decode (active-low gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 = blank.
- **On a valid decode:**
  - value pattern: write `d`*i*, set `blank[i]`=0.
  - blank pattern: `d`*i* unchanged, set `blank[i]`=1.
  - In both cases: `dp_out[i]`=~dp, set `seen[i]`, reload stale counter *i*, pulse `upd` with `upd_idx`=*i*, and OR bit *i* into a frame accumulator.
- **On an invalid pattern:** pulse `illegal`. No digit state changes. The FSM still enters HELD.
- **Frame completion:** when (accumulator | new bit) & `DIGIT_MASK` == `DIGIT_MASK`, pulse `frame_done` and clear the accumulator. This happens in the same cycle as that `upd`.
- **Staleness:** each digit has its own down-counter. When counter *i* reaches 0, clear `seen[i]`. Digit value, `blank` and `dp_out` are kept.

## Timing
- **Reset values:**
  - `d*`=0, `blank`=4'b1111, `dp_out`=0, `seen`=0.
  - `upd`=0, `upd_idx`=0, `frame_done`=0, `illegal`=0, `conflict`=0.
  - FSM=IDLE, accumulator=0, stale counters=0.
- **Latency:** pins stable from cycle N → synced sample from N+2 → all outputs registered, with `upd`/`illegal` high in cycle N+2+`SETTLE_CYCLES`.
- **Minimum dwell:** a dwell shorter than `SETTLE_CYCLES` cycles produces no accept.
- **Simultaneous events:** accept and stale expiry for the same digit in the same cycle → `seen` stays 1.
- **Reset mid-dwell:** asynchronous assertion of `rst_n` clears everything immediately. Release must see a full settle before any accept.

## Structure
- **Package `sevenseg_pkg`:**
  - the 16 pattern constants and `SEG_BLANK`.
  - FSM state enum.
  - decode function returning {valid, is_blank, value[3:0]}.
- **Sub-module `sevenseg_sync`:** parameterized-width two-flop synchronizer with an async active-low reset value input.
- **Top level:** classifier, stability counter, FSM, per-digit register file and stale counters, all inline in `sevenseg_capture`.

## Test plan
1. **Reset then hold a single digit:** hold `an`=1110, `seg`=1000000, `dp`=1 for 100 cycles, `DIGIT_MASK`=0001.
   - exactly one `upd` (idx 0), `d0`=0, `blank`=1110, `seen`=0001, one `frame_done`.
2. **Full scan:** scan digits 3..0 showing F,F,2,4 with `dp` low on digit 1, 1000 cycles each.
   - `d1`=2, `d0`=4, `dp_out`=0010, `frame_done` once per full scan.
3. **Glitch:** toggle `seg` after 10 of 16 settle cycles.
   - no `upd` until 16 stable cycles after the last change, then exactly one `upd`.
4. **Illegal pattern:** `seg`=1010101 held.
   - one `illegal` pulse, all digit outputs unchanged.
   - `an`=1100 gives one `conflict` pulse and no accept.
5. **Staleness:** `STALE_CYCLES`=64; accept digit 0, then hold `an`=1111.
   - `seen[0]` falls 64 cycles after the accept, `d0` retained.
6. **Reset mid-settle:** pulse `rst_n` low during SETTLE.
   - all outputs return to reset values immediately, and the next accept comes a full `SETTLE_CYCLES` after release.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment pattern table, dwell FSM states and pattern decoder for sevenseg_capture
package sevenseg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD, ST_CONFLICT} state_e;
  // Returns {valid, is_blank, value}; value is 0 for blank and invalid patterns.
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    logic [5:0] r;
    r = (s == SEG_BLANK) ? 6'b110000 : 6'b000000;
    for (int i = 0; i < 16; i++)
      if (s == SEG_PAT[i]) r = {2'b10, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/sevenseg_sync.sv
// sevenseg_sync: two-flop synchronizer with a selectable async reset value
module sevenseg_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= rst_val_i;
      s2_q <= rst_val_i;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: decodes a multiplexed active-low seven-segment bus back into per-digit hex values
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         STALE_CYCLES  = 2**22,
  parameter logic [3:0] DIGIT_MASK    = 4'b1111
) (
  input  logic       CLK100MHZ,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] blank,
  output logic [3:0] dp_out,
  output logic [3:0] seen,
  output logic       upd,
  output logic [1:0] upd_idx,
  output logic       frame_done,
  output logic       illegal,
  output logic       conflict
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
  logic [11:0]   smp, prev_q;
  logic [3:0]    an_s, lows, bit_sel;
  logic [6:0]    seg_s;
  logic          dp_s, changed, none, one, multi, take, valid, bad;
  logic [1:0]    idx;
  logic [5:0]    dec;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [3:0]    d_q [4];
  logic [3:0]    d_d [4];
  logic [SW-1:0] stale_q [4];
  logic [SW-1:0] stale_d [4];
  logic [3:0]    blank_q, blank_d, dpo_q, dpo_d, seen_q, seen_d, acc_q, acc_d;
  logic          frame_d, upd_q, frame_q, illegal_q, conflict_q;
  logic [1:0]    upd_idx_q;
  sevenseg_sync #(.W(12)) u_sync (
    .clk_i    (CLK100MHZ),
    .rst_n_i  (rst_n),
    .rst_val_i(12'hfff),
    .d_i      ({an, seg, dp}),
    .q_o      (smp)
  );
  assign {an_s, seg_s, dp_s} = smp;
  assign lows    = ~an_s;
  assign none    = lows == 4'd0;
  assign one     = !none && ((lows & (lows - 4'd1)) == 4'd0);
  assign multi   = !none && !one;
  assign idx     = lows[0] ? 2'd0 : lows[1] ? 2'd1 : lows[2] ? 2'd2 : 2'd3;
  assign bit_sel = 4'(1) << idx;
  assign changed = smp != prev_q;
  assign cnt_d   = changed ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign dec     = seg_decode(seg_s);
  // Only SETTLE can accept, so a HELD dwell never decodes twice.
  assign take    = state_q == ST_SETTLE && one && !changed && cnt_d == CNT_MAX;
  assign valid   = take && dec[5];
  assign bad     = take && !dec[5];
  always_comb begin
    state_d = multi ? ST_CONFLICT : none ? ST_IDLE : take ? ST_HELD :
              (state_q == ST_HELD && !changed) ? ST_HELD : ST_SETTLE;
  end
  always_comb begin
    d_d     = d_q;
    blank_d = blank_q;
    dpo_d   = dpo_q;
    seen_d  = seen_q;
    acc_d   = acc_q;
    frame_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stale_d[i] = (stale_q[i] != '0) ? stale_q[i] - SW'(1) : '0;
      if (stale_q[i] == SW'(1)) seen_d[i] = 1'b0;
    end
    if (valid) begin
      if (!dec[4]) d_d[idx] = dec[3:0];
      blank_d[idx] = dec[4];
      dpo_d[idx]   = ~dp_s;
      seen_d[idx]  = 1'b1;
      stale_d[idx] = SW'(STALE_CYCLES);
      frame_d      = ((acc_q | bit_sel) & DIGIT_MASK) == DIGIT_MASK;
      acc_d        = frame_d ? 4'd0 : acc_q | bit_sel;
    end
  end
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 12'hfff;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      d_q        <= '{default: 4'd0};
      stale_q    <= '{default: '0};
      blank_q    <= 4'b1111;
      dpo_q      <= 4'd0;
      seen_q     <= 4'd0;
      acc_q      <= 4'd0;
      upd_q      <= 1'b0;
      upd_idx_q  <= 2'd0;
      frame_q    <= 1'b0;
      illegal_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      prev_q     <= smp;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      d_q        <= d_d;
      stale_q    <= stale_d;
      blank_q    <= blank_d;
      dpo_q      <= dpo_d;
      seen_q     <= seen_d;
      acc_q      <= acc_d;
      upd_q      <= valid;
      upd_idx_q  <= valid ? idx : upd_idx_q;
      frame_q    <= frame_d;
      illegal_q  <= bad;
      conflict_q <= state_d == ST_CONFLICT && state_q != ST_CONFLICT;
    end
  end
  assign {d3, d2, d1, d0} = {d_q[3], d_q[2], d_q[1], d_q[0]};
  assign blank      = blank_q;
  assign dp_out     = dpo_q;
  assign seen       = seen_q;
  assign upd        = upd_q;
  assign upd_idx    = upd_idx_q;
  assign frame_done = frame_q;
  assign illegal    = illegal_q;
  assign conflict   = conflict_q;
endmodule
